pa_pmp_chk_pipe: RTL and testbench

Parametrised, registered PMP access checker for IFU and LSU, the next-generation replacement for the purely combinational PMP encoder. It takes per-entry hit vectors and per-entry R/W/X/L attributes for ENTRY_NUM regions and resolves the lowest-index hit. It applies machine/user privilege rules and returns a registered deny response with the faulting entry index. LSU accesses that cross a region boundary are checked as two sequential parts under a small state machine.

---
 rtl/pa_pmp_chk_pipe_if.sv | 50 +++++
 rtl/pa_pmp_chk_pipe.sv | 170 +++++++++++++++++
 tb/tb_pa_pmp_chk_pipe.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pa_pmp_chk_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : pa_pmp_chk_pipe_if
// Description : IFU and LSU request/response bundle for the registered PMP
//               access checker. The master drives requests and hit vectors;
//               the slave (checker) returns deny responses.
// Revision    : 1.0 - initial release
// ============================================================================
interface pa_pmp_chk_pipe_if #(
  parameter int ENTRY_NUM = 16
);
  localparam int IDXW = $clog2(ENTRY_NUM + 1);

  // IFU channel
  logic                 ifu_pmp_req_vld;
  logic                 ifu_pmp_machine_mode;
  logic [ENTRY_NUM-1:0] pmp_ifu_hit;
  logic                 pmp_ifu_rsp_vld;
  logic                 pmp_ifu_acc_deny;
  logic [IDXW-1:0]      pmp_ifu_deny_idx;

  // LSU channel
  logic                 lsu_pmp_req_vld;
  logic                 pmp_lsu_req_rdy;
  logic                 lsu_pmp_write;
  logic                 lsu_pmp_cross;
  logic [ENTRY_NUM-1:0] pmp_lsu_hit;
  logic                 pmp_lsu_part1;
  logic                 pmp_lsu_rsp_vld;
  logic                 pmp_lsu_acc_deny;
  logic                 pmp_lsu_deny_part;
  logic [IDXW-1:0]      pmp_lsu_deny_idx;

  modport master (
    output ifu_pmp_req_vld, ifu_pmp_machine_mode, pmp_ifu_hit,
    input  pmp_ifu_rsp_vld, pmp_ifu_acc_deny, pmp_ifu_deny_idx,
    output lsu_pmp_req_vld, lsu_pmp_write, lsu_pmp_cross, pmp_lsu_hit,
    input  pmp_lsu_req_rdy, pmp_lsu_part1, pmp_lsu_rsp_vld,
    input  pmp_lsu_acc_deny, pmp_lsu_deny_part, pmp_lsu_deny_idx
  );

  modport slave (
    input  ifu_pmp_req_vld, ifu_pmp_machine_mode, pmp_ifu_hit,
    output pmp_ifu_rsp_vld, pmp_ifu_acc_deny, pmp_ifu_deny_idx,
    input  lsu_pmp_req_vld, lsu_pmp_write, lsu_pmp_cross, pmp_lsu_hit,
    output pmp_lsu_req_rdy, pmp_lsu_part1, pmp_lsu_rsp_vld,
    output pmp_lsu_acc_deny, pmp_lsu_deny_part, pmp_lsu_deny_idx
  );
endinterface
`default_nettype wire

// File: rtl/pa_pmp_chk_pipe.sv
`default_nettype none
// ============================================================================
// Module      : pa_pmp_chk_pipe
// Description : Registered PMP access checker for IFU and LSU. Resolves the
//               lowest-index hit, applies M/U privilege rules and returns a
//               registered deny response with the deciding entry index.
//               Region-crossing LSU accesses are checked in two parts.
// Revision    : 1.0 - initial release
// ============================================================================
module pa_pmp_chk_pipe #(
  parameter int ENTRY_NUM = 16
) (
  input  wire logic                 forever_cpuclk,
  input  wire logic                 cpurst,
  input  wire logic [ENTRY_NUM-1:0] regs_comp_read,
  input  wire logic [ENTRY_NUM-1:0] regs_comp_write,
  input  wire logic [ENTRY_NUM-1:0] regs_comp_excut,
  input  wire logic [ENTRY_NUM-1:0] regs_comp_lock,
  output logic      [ENTRY_NUM-1:0] pmp_entry_lock,
  input  wire logic                 cp0_yy_mach_mode,
  input  wire logic                 cp0_pmp_mstatus_mprv,
  input  wire logic [1:0]           cp0_pmp_mstatus_mpp,
  pa_pmp_chk_pipe_if.slave          bus
);
  localparam int IDXW = $clog2(ENTRY_NUM + 1);
  localparam logic [IDXW-1:0] c_no_hit_idx = IDXW'(ENTRY_NUM);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_PART1 = 1'b1
  } lsu_state_t;

  lsu_state_t r_lsu_state;

  // Registered response state
  logic            r_ifu_rsp_vld;
  logic            r_ifu_deny;
  logic [IDXW-1:0] r_ifu_idx;
  logic            r_lsu_rdy;
  logic            r_lsu_part1;
  logic            r_lsu_rsp_vld;
  logic            r_lsu_deny;
  logic            r_lsu_part;
  logic [IDXW-1:0] r_lsu_idx;
  logic            r_lsu_m;
  logic            r_lsu_write;

  // Per-entry decisions and resolved results
  logic                 w_lsu_m_now;
  logic                 w_lsu_m_sel;
  logic                 w_lsu_wr_sel;
  logic [ENTRY_NUM-1:0] w_ifu_ent_deny;
  logic [ENTRY_NUM-1:0] w_lsu_ent_deny;
  logic [IDXW:0]        w_ifu_res;
  logic [IDXW:0]        w_lsu_res;

  // Returns {deny, idx}; lowest set hit bit wins, no hit denies only in U mode
  function automatic logic [IDXW:0] f_resolve(
    input logic [ENTRY_NUM-1:0] hit,
    input logic [ENTRY_NUM-1:0] ent_deny,
    input logic                 mode_m
  );
    logic [IDXW:0] res;
    res = {~mode_m, c_no_hit_idx};
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (hit[i]) begin
        res = {ent_deny[i], IDXW'(i)};
      end
    end
    return res;
  endfunction

  assign pmp_entry_lock = regs_comp_lock;

  // Unknown MPP encodings under MPRV fall to U mode so they can never gain M rights
  assign w_lsu_m_now  = (cp0_yy_mach_mode & ~cp0_pmp_mstatus_mprv) |
                        (cp0_pmp_mstatus_mprv & (cp0_pmp_mstatus_mpp == 2'b11));
  // Part 1 reuses the privilege and direction captured when part 0 was accepted
  assign w_lsu_m_sel  = (r_lsu_state == ST_PART1) ? r_lsu_m     : w_lsu_m_now;
  assign w_lsu_wr_sel = (r_lsu_state == ST_PART1) ? r_lsu_write : bus.lsu_pmp_write;

  for (genvar g = 0; g < ENTRY_NUM; g++) begin : g_entry
    logic w_lsu_perm;
    assign w_lsu_perm        = w_lsu_wr_sel ? regs_comp_write[g] : regs_comp_read[g];
    assign w_ifu_ent_deny[g] = bus.ifu_pmp_machine_mode ?
                               (regs_comp_lock[g] & ~regs_comp_excut[g]) :
                               ~regs_comp_excut[g];
    assign w_lsu_ent_deny[g] = w_lsu_m_sel ? (regs_comp_lock[g] & ~w_lsu_perm) :
                               ~w_lsu_perm;
  end

  assign w_ifu_res = f_resolve(bus.pmp_ifu_hit, w_ifu_ent_deny, bus.ifu_pmp_machine_mode);
  assign w_lsu_res = f_resolve(bus.pmp_lsu_hit, w_lsu_ent_deny, w_lsu_m_sel);

  // IFU single-stage pipeline: response fields only update on a request
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_ifu_rsp_vld <= 1'b0;
      r_ifu_deny    <= 1'b0;
      r_ifu_idx     <= '0;
    end else begin
      r_ifu_rsp_vld <= bus.ifu_pmp_req_vld;
      if (bus.ifu_pmp_req_vld) begin
        r_ifu_deny <= w_ifu_res[IDXW];
        r_ifu_idx  <= w_ifu_res[IDXW-1:0];
      end
    end
  end

  // LSU two-part FSM with registered handshake and response outputs
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_lsu_state   <= ST_IDLE;
      r_lsu_rdy     <= 1'b1;
      r_lsu_part1   <= 1'b0;
      r_lsu_rsp_vld <= 1'b0;
      r_lsu_deny    <= 1'b0;
      r_lsu_part    <= 1'b0;
      r_lsu_idx     <= '0;
      r_lsu_m       <= 1'b0;
      r_lsu_write   <= 1'b0;
    end else begin
      r_lsu_rsp_vld <= 1'b0;
      case (r_lsu_state)
        ST_IDLE: begin
          if (bus.lsu_pmp_req_vld) begin
            r_lsu_m     <= w_lsu_m_now;
            r_lsu_write <= bus.lsu_pmp_write;
            if (!bus.lsu_pmp_cross || w_lsu_res[IDXW]) begin
              // Single part, or part 0 already faulted: part 1 is skipped
              r_lsu_rsp_vld <= 1'b1;
              r_lsu_deny    <= w_lsu_res[IDXW];
              r_lsu_part    <= 1'b0;
              r_lsu_idx     <= w_lsu_res[IDXW-1:0];
            end else begin
              r_lsu_state <= ST_PART1;
              r_lsu_rdy   <= 1'b0;
              r_lsu_part1 <= 1'b1;
            end
          end
        end
        ST_PART1: begin
          r_lsu_rsp_vld <= 1'b1;
          r_lsu_deny    <= w_lsu_res[IDXW];
          r_lsu_part    <= w_lsu_res[IDXW];
          r_lsu_idx     <= w_lsu_res[IDXW-1:0];
          r_lsu_state   <= ST_IDLE;
          r_lsu_rdy     <= 1'b1;
          r_lsu_part1   <= 1'b0;
        end
        default: begin
          r_lsu_state <= ST_IDLE;
          r_lsu_rdy   <= 1'b1;
          r_lsu_part1 <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pmp_ifu_rsp_vld   = r_ifu_rsp_vld;
  assign bus.pmp_ifu_acc_deny  = r_ifu_deny;
  assign bus.pmp_ifu_deny_idx  = r_ifu_idx;
  assign bus.pmp_lsu_req_rdy   = r_lsu_rdy;
  assign bus.pmp_lsu_part1     = r_lsu_part1;
  assign bus.pmp_lsu_rsp_vld   = r_lsu_rsp_vld;
  assign bus.pmp_lsu_acc_deny  = r_lsu_deny;
  assign bus.pmp_lsu_deny_part = r_lsu_part;
  assign bus.pmp_lsu_deny_idx  = r_lsu_idx;
endmodule
`default_nettype wire

// File: tb/tb_pa_pmp_chk_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_pa_pmp_chk_pipe
// Description : Directed, table-driven bench for pa_pmp_chk_pipe with
//               hand-written sequences for crossing accesses and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pa_pmp_chk_pipe;
  localparam int ENTRY_NUM = 16;

  logic        clk;
  logic        rst;
  logic [15:0] rd, wp, ex, lk;
  logic [15:0] lock_out;
  logic        mach, mprv;
  logic [1:0]  mpp;

  int n_cmp = 0;
  int n_err = 0;

  pa_pmp_chk_pipe_if #(.ENTRY_NUM(ENTRY_NUM)) bus ();

  pa_pmp_chk_pipe #(.ENTRY_NUM(ENTRY_NUM)) dut (
    .forever_cpuclk       (clk),
    .cpurst               (rst),
    .regs_comp_read       (rd),
    .regs_comp_write      (wp),
    .regs_comp_excut      (ex),
    .regs_comp_lock       (lk),
    .pmp_entry_lock       (lock_out),
    .cp0_yy_mach_mode     (mach),
    .cp0_pmp_mstatus_mprv (mprv),
    .cp0_pmp_mstatus_mpp  (mpp),
    .bus                  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_lsu;
    logic        ifu_m;
    logic        mach;
    logic        mprv;
    logic [1:0]  mpp;
    logic        wr;
    logic [15:0] hit;
    logic [15:0] rd;
    logic [15:0] wp;
    logic [15:0] ex;
    logic [15:0] lk;
    logic        exp_deny;
    logic [4:0]  exp_idx;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    //                 lsu ifm mch mpv mpp  wr  hit       rd        wp        ex        lk        dny idx
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,16'h0006,16'hffff,16'hffff,16'h0004,16'h0000,1'b1,5'd1};
    vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,16'h0000,16'hffff,16'hffff,16'hffff,16'h0000,1'b0,5'd16};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,16'h0000,16'hffff,16'hffff,16'hffff,16'h0000,1'b1,5'd16};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,16'h0010,16'hffff,16'hffff,16'hffef,16'h0010,1'b1,5'd4};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,16'h0010,16'hffff,16'hffff,16'hffef,16'h0000,1'b0,5'd4};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,16'h8000,16'hffff,16'hffff,16'hffff,16'h0000,1'b0,5'd15};
    vecs[6]  = '{1'b1,1'b0,1'b1,1'b0,2'b00,1'b1,16'h0001,16'hffff,16'hfffe,16'hffff,16'h0000,1'b0,5'd0};
    vecs[7]  = '{1'b1,1'b0,1'b1,1'b0,2'b00,1'b1,16'h0001,16'hffff,16'hfffe,16'hffff,16'h0001,1'b1,5'd0};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,16'h0008,16'hffff,16'hffff,16'hffff,16'h0000,1'b0,5'd3};
    vecs[9]  = '{1'b1,1'b0,1'b1,1'b1,2'b01,1'b0,16'h0000,16'hffff,16'hffff,16'hffff,16'h0000,1'b1,5'd16};
    vecs[10] = '{1'b1,1'b0,1'b0,1'b1,2'b11,1'b0,16'h0000,16'hffff,16'hffff,16'hffff,16'h0000,1'b0,5'd16};
    vecs[11] = '{1'b1,1'b0,1'b1,1'b0,2'b00,1'b1,16'h0003,16'hffff,16'h0002,16'hffff,16'h0001,1'b1,5'd0};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,16'h0c00,16'hf7ff,16'h0000,16'hffff,16'h0000,1'b0,5'd10};
    vecs[13] = '{1'b1,1'b0,1'b1,1'b1,2'b10,1'b1,16'h0004,16'hffff,16'hfffb,16'hffff,16'h0000,1'b1,5'd2};

    // Reset state
    rst = 1'b1;
    rd = '1; wp = '1; ex = '1; lk = '0;
    mach = 1'b0; mprv = 1'b0; mpp = 2'b00;
    bus.ifu_pmp_req_vld = 1'b0; bus.ifu_pmp_machine_mode = 1'b0; bus.pmp_ifu_hit = '0;
    bus.lsu_pmp_req_vld = 1'b0; bus.lsu_pmp_write = 1'b0; bus.lsu_pmp_cross = 1'b0;
    bus.pmp_lsu_hit = '0;
    tick();
    tick();
    chk("rst_ifu_rsp_vld", 32'(bus.pmp_ifu_rsp_vld), 0);
    chk("rst_ifu_deny", 32'(bus.pmp_ifu_acc_deny), 0);
    chk("rst_ifu_idx", 32'(bus.pmp_ifu_deny_idx), 0);
    chk("rst_lsu_rsp_vld", 32'(bus.pmp_lsu_rsp_vld), 0);
    chk("rst_lsu_deny", 32'(bus.pmp_lsu_acc_deny), 0);
    chk("rst_lsu_part", 32'(bus.pmp_lsu_deny_part), 0);
    chk("rst_lsu_idx", 32'(bus.pmp_lsu_deny_idx), 0);
    chk("rst_part1", 32'(bus.pmp_lsu_part1), 0);
    rst = 1'b0;
    tick();
    chk("rst_rdy", 32'(bus.pmp_lsu_req_rdy), 1);

    // Lock mirror is combinational
    lk = 16'ha5a5;
    #1;
    chk("entry_lock", 32'(lock_out), 32'h0000a5a5);

    // Table-driven single-cycle checks
    for (int i = 0; i < 14; i++) begin
      rd = vecs[i].rd; wp = vecs[i].wp; ex = vecs[i].ex; lk = vecs[i].lk;
      mach = vecs[i].mach; mprv = vecs[i].mprv; mpp = vecs[i].mpp;
      bus.ifu_pmp_machine_mode = vecs[i].ifu_m;
      bus.pmp_ifu_hit = vecs[i].hit;
      bus.pmp_lsu_hit = vecs[i].hit;
      bus.lsu_pmp_write = vecs[i].wr;
      bus.lsu_pmp_cross = 1'b0;
      bus.ifu_pmp_req_vld = ~vecs[i].is_lsu;
      bus.lsu_pmp_req_vld = vecs[i].is_lsu;
      tick();
      bus.ifu_pmp_req_vld = 1'b0;
      bus.lsu_pmp_req_vld = 1'b0;
      if (vecs[i].is_lsu) begin
        chk($sformatf("v%0d_lsu_rsp_vld", i), 32'(bus.pmp_lsu_rsp_vld), 1);
        chk($sformatf("v%0d_lsu_deny", i), 32'(bus.pmp_lsu_acc_deny), 32'(vecs[i].exp_deny));
        chk($sformatf("v%0d_lsu_idx", i), 32'(bus.pmp_lsu_deny_idx), 32'(vecs[i].exp_idx));
        chk($sformatf("v%0d_lsu_part", i), 32'(bus.pmp_lsu_deny_part), 0);
        chk($sformatf("v%0d_lsu_rdy", i), 32'(bus.pmp_lsu_req_rdy), 1);
      end else begin
        chk($sformatf("v%0d_ifu_rsp_vld", i), 32'(bus.pmp_ifu_rsp_vld), 1);
        chk($sformatf("v%0d_ifu_deny", i), 32'(bus.pmp_ifu_acc_deny), 32'(vecs[i].exp_deny));
        chk($sformatf("v%0d_ifu_idx", i), 32'(bus.pmp_ifu_deny_idx), 32'(vecs[i].exp_idx));
      end
    end

    // Idle cycle: pulses drop, fields hold the last LSU result (vector 13)
    tick();
    chk("idle_lsu_rsp_vld", 32'(bus.pmp_lsu_rsp_vld), 0);
    chk("idle_ifu_rsp_vld", 32'(bus.pmp_ifu_rsp_vld), 0);
    chk("hold_lsu_deny", 32'(bus.pmp_lsu_acc_deny), 1);
    chk("hold_lsu_idx", 32'(bus.pmp_lsu_deny_idx), 2);

    // Back-to-back IFU in U mode: entry 1 allowed, then no hit denied
    rd = '1; wp = '1; ex = '1; lk = '0;
    bus.ifu_pmp_machine_mode = 1'b0;
    bus.ifu_pmp_req_vld = 1'b1;
    bus.pmp_ifu_hit = 16'h0002;
    tick();
    chk("b2b0_vld", 32'(bus.pmp_ifu_rsp_vld), 1);
    chk("b2b0_deny", 32'(bus.pmp_ifu_acc_deny), 0);
    chk("b2b0_idx", 32'(bus.pmp_ifu_deny_idx), 1);
    bus.pmp_ifu_hit = 16'h0000;
    tick();
    bus.ifu_pmp_req_vld = 1'b0;
    chk("b2b1_vld", 32'(bus.pmp_ifu_rsp_vld), 1);
    chk("b2b1_deny", 32'(bus.pmp_ifu_acc_deny), 1);
    chk("b2b1_idx", 32'(bus.pmp_ifu_deny_idx), 16);

    // Crossing U-mode load: part 0 entry 3 readable, part 1 entry 5 not
    rd = 16'hffdf; wp = '1; lk = '0;
    mach = 1'b0; mprv = 1'b0; mpp = 2'b00;
    bus.lsu_pmp_write = 1'b0;
    bus.lsu_pmp_cross = 1'b1;
    bus.pmp_lsu_hit = 16'h0008;
    bus.lsu_pmp_req_vld = 1'b1;
    tick();
    bus.lsu_pmp_req_vld = 1'b0;
    chk("x1_part1", 32'(bus.pmp_lsu_part1), 1);
    chk("x1_rdy", 32'(bus.pmp_lsu_req_rdy), 0);
    chk("x1_rsp_vld", 32'(bus.pmp_lsu_rsp_vld), 0);
    // Changing live mode/direction must not affect part 1 (captured U load)
    mach = 1'b1;
    bus.lsu_pmp_write = 1'b1;
    bus.lsu_pmp_cross = 1'b0;
    bus.pmp_lsu_hit = 16'h0020;
    tick();
    chk("x2_rsp_vld", 32'(bus.pmp_lsu_rsp_vld), 1);
    chk("x2_deny", 32'(bus.pmp_lsu_acc_deny), 1);
    chk("x2_part", 32'(bus.pmp_lsu_deny_part), 1);
    chk("x2_idx", 32'(bus.pmp_lsu_deny_idx), 5);
    chk("x2_part1", 32'(bus.pmp_lsu_part1), 0);
    chk("x2_rdy", 32'(bus.pmp_lsu_req_rdy), 1);

    // Crossing access with part 0 denied terminates early
    mach = 1'b0;
    rd = 16'hfff7;
    bus.lsu_pmp_write = 1'b0;
    bus.lsu_pmp_cross = 1'b1;
    bus.pmp_lsu_hit = 16'h0008;
    bus.lsu_pmp_req_vld = 1'b1;
    tick();
    bus.lsu_pmp_req_vld = 1'b0;
    chk("e1_rsp_vld", 32'(bus.pmp_lsu_rsp_vld), 1);
    chk("e1_deny", 32'(bus.pmp_lsu_acc_deny), 1);
    chk("e1_part", 32'(bus.pmp_lsu_deny_part), 0);
    chk("e1_idx", 32'(bus.pmp_lsu_deny_idx), 3);
    chk("e1_part1", 32'(bus.pmp_lsu_part1), 0);
    tick();
    chk("e2_part1", 32'(bus.pmp_lsu_part1), 0);
    chk("e2_rsp_vld", 32'(bus.pmp_lsu_rsp_vld), 0);

    // Reset asserted during PART1 drops the pending response
    rd = '1;
    bus.pmp_lsu_hit = 16'h0008;
    bus.lsu_pmp_req_vld = 1'b1;
    tick();
    bus.lsu_pmp_req_vld = 1'b0;
    bus.lsu_pmp_cross = 1'b0;
    chk("r_part1", 32'(bus.pmp_lsu_part1), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("r_part1_clr", 32'(bus.pmp_lsu_part1), 0);
    tick();
    chk("r_rsp_vld_a", 32'(bus.pmp_lsu_rsp_vld), 0);
    rst = 1'b0;
    tick();
    chk("r_rsp_vld_b", 32'(bus.pmp_lsu_rsp_vld), 0);
    chk("r_rdy", 32'(bus.pmp_lsu_req_rdy), 1);
    rd = 16'h0001;
    bus.pmp_lsu_hit = 16'h0001;
    bus.lsu_pmp_req_vld = 1'b1;
    tick();
    bus.lsu_pmp_req_vld = 1'b0;
    chk("r_next_vld", 32'(bus.pmp_lsu_rsp_vld), 1);
    chk("r_next_deny", 32'(bus.pmp_lsu_acc_deny), 0);
    chk("r_next_idx", 32'(bus.pmp_lsu_deny_idx), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
